// File: rtl/psram_qpi_responder.sv
// QPI PSRAM responder model: SPI/QPI command decode, 24-bit addressed byte writes and
// wait-state-delayed burst reads from an internal byte array, all in the clk domain.
module psram_qpi_responder #(
    parameter int unsigned WAIT_CYCLES = 6,
    parameter int unsigned MEM_AW      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       psram_cs,
    input  logic       psram_sclk,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic       sio_oe,
    output logic       qpi_mode,
    output logic       cmd_err
);

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;

    localparam logic [7:0] OP_QPI_ENTER = 8'h35;
    localparam logic [7:0] OP_QPI_EXIT  = 8'hF5;
    localparam logic [7:0] OP_WRITE     = 8'h38;
    localparam logic [7:0] OP_READ      = 8'hEB;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WR_DATA,
        S_WAIT,
        S_RD_DATA,
        S_IGNORE
    } state_t;

    state_t             state;
    logic [1:0]         cs_sync;
    logic [1:0]         sclk_sync;
    logic [3:0]         sio_meta;
    logic [3:0]         sio_s;
    logic               sclk_q;
    logic               cs_s;
    logic               sclk_s;
    logic               rise;
    logic               fall;
    logic [CNT_W-1:0]   cnt;
    logic [6:0]         cmd_sh;
    logic [7:0]         cmd_byte;
    logic               cmd_last;
    logic [MEM_AW-1:0]  ptr;
    logic [3:0]         hi_nib;
    logic               is_read;
    logic               wr_en;
    logic [7:0]         rd_byte;
    logic [7:0]         mem [MEM_DEPTH];

    // Two-flop synchronizers plus one stage of sclk history for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_sync   <= 2'b11;
            sclk_sync <= 2'b00;
            sio_meta  <= 4'h0;
            sio_s     <= 4'h0;
            sclk_q    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], psram_cs};
            sclk_sync <= {sclk_sync[0], psram_sclk};
            sio_meta  <= sio_in;
            sio_s     <= sio_meta;
            sclk_q    <= sclk_sync[1];
        end
    end

    always_comb begin
        cs_s     = cs_sync[1];
        sclk_s   = sclk_sync[1];
        rise     = sclk_s & ~sclk_q;
        fall     = ~sclk_s & sclk_q;
        cmd_byte = qpi_mode ? {cmd_sh[3:0], sio_s} : {cmd_sh, sio_s[0]};
        cmd_last = qpi_mode ? (cnt == CNT_W'(1)) : (cnt == CNT_W'(7));
        // A byte lands only on its second nibble, so a cs abort never commits a half byte
        wr_en    = reset && !cs_s && (state == S_WR_DATA) && rise && cnt[0];
        rd_byte  = mem[ptr];
    end

    // Byte array is deliberately outside the reset domain so contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr] <= {hi_nib, sio_s};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cmd_sh   <= '0;
            ptr      <= '0;
            hi_nib   <= 4'h0;
            is_read  <= 1'b0;
            qpi_mode <= 1'b0;
            cmd_err  <= 1'b0;
            sio_oe   <= 1'b0;
            sio_out  <= 4'h0;
        end else if (cs_s) begin
            state  <= S_IDLE;
            sio_oe <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state  <= S_CMD;
                    cnt    <= '0;
                    cmd_sh <= '0;
                end
                S_CMD: begin
                    if (rise) begin
                        cmd_sh <= cmd_byte[6:0];
                        cnt    <= cnt + CNT_W'(1);
                        if (cmd_last) begin
                            cnt <= '0;
                            if (!qpi_mode) begin
                                if (cmd_byte == OP_QPI_ENTER) qpi_mode <= 1'b1;
                                else                          cmd_err  <= 1'b1;
                                state <= S_IGNORE;
                            end else begin
                                case (cmd_byte)
                                    OP_QPI_EXIT: begin
                                        qpi_mode <= 1'b0;
                                        state    <= S_IGNORE;
                                    end
                                    OP_WRITE: begin
                                        is_read <= 1'b0;
                                        state   <= S_ADDR;
                                    end
                                    OP_READ: begin
                                        is_read <= 1'b1;
                                        state   <= S_ADDR;
                                    end
                                    default: begin
                                        cmd_err <= 1'b1;
                                        state   <= S_IGNORE;
                                    end
                                endcase
                            end
                        end
                    end
                end
                S_ADDR: begin
                    // Shifting into an MEM_AW-wide pointer drops the unused upper address bits
                    if (rise) begin
                        ptr <= MEM_AW'({ptr, sio_s});
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(5)) begin
                            cnt   <= '0;
                            state <= is_read ? S_WAIT : S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (rise) begin
                        if (!cnt[0]) begin
                            hi_nib <= sio_s;
                            cnt    <= CNT_W'(1);
                        end else begin
                            cnt <= '0;
                            ptr <= ptr + MEM_AW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (rise) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
                            cnt   <= '0;
                            state <= S_RD_DATA;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (fall) begin
                        sio_oe <= 1'b1;
                        if (!cnt[0]) begin
                            sio_out <= rd_byte[7:4];
                            cnt     <= CNT_W'(1);
                        end else begin
                            sio_out <= rd_byte[3:0];
                            cnt     <= '0;
                            ptr     <= ptr + MEM_AW'(1);
                        end
                    end
                end
                S_IGNORE: begin
                    state <= S_IGNORE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/psram_qpi_responder.md
PSRAM_QPI_RESPONDER -- requirements
Module: psram_qpi_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 6: number of sclk wait cycles between the last address nibble and the first read-data nibble.
REQ-002 SHALL have parameter MEM_AW, default 8: internal byte-array address width (2^MEM_AW bytes).
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic in this domain; frequency at least 4x psram_sclk.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port psram_cs, input, 1 bit: chip select from initiator, active-low.
REQ-006 SHALL have port psram_sclk, input, 1 bit: serial clock from initiator; idles low.
REQ-007 SHALL have port sio_in, input, 4 bits: data pins as seen by responder; bit0 is SI in SPI mode.
REQ-008 SHALL have port sio_out, output, 4 bits: read data nibble to initiator.
REQ-009 SHALL have port sio_oe, output, 1 bit: 1 = responder drives all four sio pins.
REQ-010 SHALL have port qpi_mode, output, 1 bit: 1 = device in QPI (4-bit) mode.
REQ-011 SHALL have port cmd_err, output, 1 bit: sticky flag set by an unsupported opcode.

Function
REQ-012 SHALL pass psram_cs, psram_sclk and sio_in through 2-flop synchronizers; edges SHALL be detected on synchronized signals only.
REQ-013 SHALL sample sio_in on each detected sclk rising edge while cs is low, and SHALL update sio_out only on detected sclk falling edges.
REQ-014 SHALL implement states IDLE, CMD, ADDR, WR_DATA, WAIT, RD_DATA, IGNORE.
REQ-015 IDLE: synchronized cs low -> CMD with bit/nibble counter cleared.
REQ-016 CMD, SPI mode: 8 bits on sio_in[0], MSB first; CMD, QPI mode: 2 nibbles, high nibble first.
REQ-017 Opcode 0x35 in SPI mode SHALL set qpi_mode=1 after the 8th bit, then -> IGNORE.
REQ-018 Opcode 0xF5 in QPI mode SHALL clear qpi_mode after the 2nd nibble, then -> IGNORE.
REQ-019 Opcodes 0x38 (write) and 0xEB (read) in QPI mode -> ADDR.
REQ-020 Any other opcode, or 0x38/0xEB in SPI mode, SHALL set cmd_err=1 and -> IGNORE.
REQ-021 ADDR: 6 nibbles (24-bit address), MSB nibble first; only addr[MEM_AW-1:0] is used, upper bits ignored.
REQ-022 After 6th nibble: write -> WR_DATA; read -> WAIT.
REQ-023 WR_DATA: each pair of nibbles (high first) SHALL write one byte to mem[addr]; then addr increments modulo 2^MEM_AW.
REQ-024 WAIT: count WAIT_CYCLES rising edges, sio_oe=0 throughout; -> RD_DATA.
REQ-025 RD_DATA: on the falling edge ending the last wait cycle, sio_oe=1 and sio_out=mem[addr][7:4]; next falling edge mem[addr][3:0]; then addr increments modulo 2^MEM_AW and the sequence repeats.
REQ-026 Burst length SHALL be unlimited; wrap from address 2^MEM_AW-1 to 0 is silent.
REQ-027 Synchronized cs rising from any state SHALL force IDLE and sio_oe=0 within 3 clk of the raw cs edge.
REQ-028 cs rising mid-byte in WR_DATA SHALL discard the partial byte; mem is unchanged.
REQ-029 cs rising mid-CMD or mid-ADDR SHALL leave qpi_mode, cmd_err and mem unchanged.
REQ-030 cmd_err SHALL stay set until reset.
REQ-031 IGNORE SHALL discard all sclk edges until cs high.

Reset
REQ-032 On reset low: state=IDLE, qpi_mode=0, cmd_err=0, sio_oe=0, sio_out=4'h0, counters and address cleared, synchronizers set to cs=1 and sclk=0.
REQ-033 mem contents SHALL NOT be cleared by reset.
REQ-034 Reset asserted mid-transaction SHALL take effect immediately (asynchronous); no write completes after reset asserts.

Verification
REQ-035 SPI 0x35 (8 bits on sio_in[0]), cs high -> qpi_mode=1, cmd_err=0, sio_oe never 1.
REQ-036 QPI write 0x38, address 0x00C000, data 0xAA, 0x55; then read 0xEB at 0x00C000 -> after 6 wait cycles sio_out = A,A,5,5; sio_oe=1 only in RD_DATA.
REQ-037 Write 0x11, 0x22 at address 0x0000FF, then read 2 bytes from 0x0000FF -> 0x11 then 0x22 (wrap to 0x00).
REQ-038 QPI write to 0x000010 of 0x3 then cs high after 1 nibble -> mem[0x10] unchanged on readback.
REQ-039 QPI opcode 0x9F -> cmd_err=1, no sio_oe; next 0x38/0xEB transactions still work and cmd_err stays 1.
REQ-040 Reset low during RD_DATA -> sio_oe=0, qpi_mode=0 immediately; after release, SPI 0x35 is needed before reads, and previously written data reads back intact.
